// File: rtl/fifo_uart_tx.sv
// Serialises a captured 64-bit word as eight back-to-back UART 8N1 bytes, byte 0 first.
// A rising edge on start while idle launches one frame; tx_done pulses once at the end.
module fifo_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic        clk_fifo_i,
    input  logic        reset,
    input  logic        start,
    input  logic [63:0] data_in,
    output logic        tx_serial,
    output logic        tx_busy,
    output logic        tx_done,
    output logic [2:0]  byte_idx
);

    localparam int unsigned CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START_BIT,
        DATA_BITS,
        STOP_BIT,
        DONE
    } state_e;

    state_e        state_q, state_d;
    logic          start_q;
    logic [63:0]   hold_q, hold_d;
    logic [2:0]    byte_idx_q, byte_idx_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [CW-1:0] clk_cnt_q, clk_cnt_d;
    logic          tx_serial_q, tx_serial_d;

    logic start_edge;
    logic bit_last;

    assign start_edge = start & ~start_q;
    assign bit_last   = (clk_cnt_q == CNT_LAST);

    // NOTE: state uses non-blocking assignments so every register samples the
    // pre-edge values; blocking here would create order-dependent races.
    // NOTE: the 64-bit holding register is reset too, so an aborted frame
    // leaves no stale payload behind.
    always_ff @(posedge clk_fifo_i or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            start_q     <= 1'b0;
            hold_q      <= '0;
            byte_idx_q  <= '0;
            bit_cnt_q   <= '0;
            clk_cnt_q   <= '0;
            tx_serial_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            start_q     <= start;
            hold_q      <= hold_d;
            byte_idx_q  <= byte_idx_d;
            bit_cnt_q   <= bit_cnt_d;
            clk_cnt_q   <= clk_cnt_d;
            tx_serial_q <= tx_serial_d;
        end
    end

    // NOTE: every output of this block gets a hold-value default first so no
    // path through the case statement can infer a latch.
    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        byte_idx_d = byte_idx_q;
        bit_cnt_d  = bit_cnt_q;
        clk_cnt_d  = clk_cnt_q;

        case (state_q)
            IDLE: begin
                if (start_edge) begin
                    hold_d     = data_in;
                    byte_idx_d = '0;
                    bit_cnt_d  = '0;
                    clk_cnt_d  = '0;
                    state_d    = START_BIT;
                end
            end

            START_BIT: begin
                if (bit_last) begin
                    clk_cnt_d = '0;
                    bit_cnt_d = '0;
                    state_d   = DATA_BITS;
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end

            DATA_BITS: begin
                if (bit_last) begin
                    clk_cnt_d = '0;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = STOP_BIT;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end

            STOP_BIT: begin
                if (bit_last) begin
                    clk_cnt_d = '0;
                    if (byte_idx_q == 3'd7) begin
                        state_d = DONE;
                    end else begin
                        byte_idx_d = byte_idx_q + 3'd1;
                        state_d    = START_BIT;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Line level is decoded from the next state so the registered pin changes
    // on the same edge as the state it belongs to.
    always_comb begin
        tx_serial_d = 1'b1;
        case (state_d)
            START_BIT: tx_serial_d = 1'b0;
            DATA_BITS: tx_serial_d = hold_d[{byte_idx_d, bit_cnt_d}];
            default:   tx_serial_d = 1'b1;
        endcase
    end

    assign tx_serial = tx_serial_q;
    assign tx_busy   = (state_q == START_BIT) || (state_q == DATA_BITS) || (state_q == STOP_BIT);
    assign tx_done   = (state_q == DONE);
    assign byte_idx  = byte_idx_q;

endmodule

// File: doc/fifo_uart_tx.md
FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 16, giving the clock cycles per UART bit period (legal range 2..65535).
REQ-002 The block SHALL have port clk_fifo_i  input  1  system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 The block SHALL have port start  input  1  level request; a 0->1 transition while idle launches one 8-byte frame.
REQ-005 The block SHALL have port data_in  input  64  word to send; byte k = data_in[8k+7:8k].
REQ-006 The block SHALL have port tx_serial  output  1  UART 8N1 serial line, idle high.
REQ-007 The block SHALL have port tx_busy  output  1  high while a frame is being shifted out.
REQ-008 The block SHALL have port tx_done  output  1  one-cycle pulse after the final stop bit.
REQ-009 The block SHALL have port byte_idx  output  3  index (0..7) of the byte currently on the line.

Function
REQ-010 The block SHALL register start every cycle into start_q; edge = start & ~start_q.
REQ-011 The FSM SHALL have states IDLE, START_BIT, DATA_BITS, STOP_BIT, DONE.
REQ-012 In IDLE with edge=1, the block SHALL capture data_in into a 64-bit holding register, clear byte_idx, and enter START_BIT on the next cycle.
REQ-013 Edges arriving outside IDLE SHALL be ignored and not queued; start_q SHALL still track start.
REQ-014 data_in changes after the capture cycle SHALL NOT affect the frame in progress.
REQ-015 The START_BIT state SHALL drive tx_serial=0 for exactly CLKS_PER_BIT cycles.
REQ-016 The DATA_BITS state SHALL send 8 bits of byte byte_idx, LSB first, each for exactly CLKS_PER_BIT cycles, using a 3-bit bit counter.
REQ-017 The STOP_BIT state SHALL drive tx_serial=1 for exactly CLKS_PER_BIT cycles.
REQ-018 At the end of STOP_BIT with byte_idx<7, the block SHALL increment byte_idx and enter START_BIT with no idle gap.
REQ-019 At the end of STOP_BIT with byte_idx=7, the block SHALL enter DONE.
REQ-020 DONE SHALL last one cycle (tx_done=1, tx_busy=0, tx_serial=1) and then return to IDLE.
REQ-021 tx_busy SHALL be 1 exactly in START_BIT, DATA_BITS and STOP_BIT.
REQ-022 tx_serial SHALL be a registered output (glitch-free) and SHALL be 1 in IDLE and DONE.
REQ-023 The bit-period counter SHALL be sized ceil(log2(CLKS_PER_BIT)) bits, count 0..CLKS_PER_BIT-1, and reload to 0 at each bit boundary.
REQ-024 Frame length from START_BIT entry to DONE entry SHALL be exactly 80*CLKS_PER_BIT cycles.
REQ-025 Because start_q resets to 0, a start held high through reset release SHALL launch exactly one frame.
REQ-026 A start level held high after DONE SHALL NOT relaunch; a new 0->1 transition is required.

Reset
REQ-027 Asserting reset SHALL immediately, without a clock edge, force state=IDLE, tx_serial=1, tx_busy=0, tx_done=0, byte_idx=0, holding register=0, all counters=0 and start_q=0.
REQ-028 Reset asserted mid-frame SHALL abort the frame with no tx_done pulse; the next edge after release SHALL start a fresh frame at byte 0.

Verification (CLKS_PER_BIT=4)
REQ-029 Reset check: assert reset asynchronously between clock edges -> tx_serial=1, tx_busy=0, tx_done=0, byte_idx=0 immediately.
REQ-030 Nominal frame: data_in=64'h0807060504030201, start 0->1 -> line carries bytes 01,02,...,08 LSB first, each framed 0/data/1; tx_busy high for 320 cycles; single tx_done pulse.
REQ-031 Held start: keep start=1 after frame done -> no further start bit; a 1->0->1 toggle -> second frame.
REQ-032 Busy-time stimulus: during byte 2, toggle start and change data_in to 64'hFFFFFFFFFFFFFFFF -> original bytes are sent unaltered and no second frame follows.
REQ-033 Mid-frame reset: reset during byte 3 data bits -> line high, busy 0, no tx_done; then data_in=64'h0, start edge -> 8 bytes of 0x00 are sent (line low for 9 bit periods per byte), ending with tx_done.
